// File: rtl/vram_port_scheduler.sv
// Owns both ports of a simple dual-port VRAM: round-robin read arbitration with
// write-collision stalling, plus a host-write / clear-fill mux onto the write port.
module vram_port_scheduler #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd0_valid,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_ready,
  input  logic              rd1_valid,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_value,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_read_data
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_nxt;
  logic [DATA_W-1:0] r_clr_val, w_clr_val_nxt;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_rsp0, r_rsp1;
  logic              w_elig0, w_elig1, w_gnt0, w_gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      r_clr_val <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_clr_val <= w_clr_val_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_cnt_nxt  = r_clr_cnt;
    w_clr_val_nxt  = r_clr_val;
    wr_ready       = 1'b0;
    ram_write_en   = 1'b0;
    ram_waddr      = wr_addr;
    ram_write_data = wr_data;
    case (r_state)
      ST_IDLE: begin
        wr_ready     = rst_n;
        ram_write_en = rst_n & wr_valid;
        if (clear_start) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = '0;
          w_clr_val_nxt = clear_value;
        end
      end
      ST_CLEAR: begin
        ram_write_en   = rst_n;
        ram_waddr      = r_clr_cnt;
        ram_write_data = r_clr_val;
        w_clr_cnt_nxt  = r_clr_cnt + 1'b1;
        if (r_clr_cnt == '1) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign clear_busy = (r_state == ST_CLEAR);

  // A requester reading the word being written this cycle waits a cycle.
  assign w_elig0 = rst_n & rd0_valid & ~(ram_write_en & (rd0_addr == ram_waddr));
  assign w_elig1 = rst_n & rd1_valid & ~(ram_write_en & (rd1_addr == ram_waddr));
  assign w_gnt0  = w_elig0 & (~w_elig1 | r_last_grant);
  assign w_gnt1  = w_elig1 & (~w_elig0 | ~r_last_grant);

  assign rd0_ready = w_gnt0;
  assign rd1_ready = w_gnt1;
  assign ram_raddr = w_gnt0 ? rd0_addr : (w_gnt1 ? rd1_addr : r_raddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_raddr      <= '0;
      r_rsp0       <= 1'b0;
      r_rsp1       <= 1'b0;
    end else begin
      if (w_gnt0)      r_last_grant <= 1'b0;
      else if (w_gnt1) r_last_grant <= 1'b1;
      r_raddr <= ram_raddr;
      r_rsp0  <= w_gnt0;
      r_rsp1  <= w_gnt1;
    end
  end

  assign rsp0_valid = r_rsp0;
  assign rsp1_valid = r_rsp1;
  assign rsp0_data  = ram_read_data;
  assign rsp1_data  = ram_read_data;

endmodule

// File: tb/tb_vram_port_scheduler.sv
// Directed bench: a 10-bit instance for read/arbitration/collision and a 4-bit
// instance for clear behaviour, each backed by a small registered-read RAM model.
module tb_vram_port_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 10-bit address instance
  logic       rst_n;
  logic       rd0_valid, rd1_valid, rd0_ready, rd1_ready;
  logic [9:0] rd0_addr, rd1_addr;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic       wr_valid, wr_ready;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       clear_start, clear_busy;
  logic [7:0] clear_value;
  logic [9:0] ram_waddr, ram_raddr;
  logic [7:0] ram_write_data, ram_read_data;
  logic       ram_write_en;
  logic [7:0] mem_b [0:1023];

  vram_port_scheduler #(.ADDR_W(10), .DATA_W(8)) u_big (
    .clk(clk), .rst_n(rst_n),
    .rd0_valid(rd0_valid), .rd0_addr(rd0_addr), .rd0_ready(rd0_ready),
    .rd1_valid(rd1_valid), .rd1_addr(rd1_addr), .rd1_ready(rd1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clear_start(clear_start), .clear_value(clear_value), .clear_busy(clear_busy),
    .ram_waddr(ram_waddr), .ram_write_data(ram_write_data), .ram_write_en(ram_write_en),
    .ram_raddr(ram_raddr), .ram_read_data(ram_read_data)
  );

  always @(posedge clk) begin
    if (ram_write_en) mem_b[ram_waddr] <= ram_write_data;
    ram_read_data <= mem_b[ram_raddr];
  end

  // 4-bit address instance
  logic       s_rst_n;
  logic       s_rd0_valid, s_rd1_valid, s_rd0_ready, s_rd1_ready;
  logic [3:0] s_rd0_addr, s_rd1_addr;
  logic       s_rsp0_valid, s_rsp1_valid;
  logic [7:0] s_rsp0_data, s_rsp1_data;
  logic       s_wr_valid, s_wr_ready;
  logic [3:0] s_wr_addr;
  logic [7:0] s_wr_data;
  logic       s_clear_start, s_clear_busy;
  logic [7:0] s_clear_value;
  logic [3:0] s_ram_waddr, s_ram_raddr;
  logic [7:0] s_ram_write_data, s_ram_read_data;
  logic       s_ram_write_en;
  logic [7:0] mem_s [0:15];

  vram_port_scheduler #(.ADDR_W(4), .DATA_W(8)) u_small (
    .clk(clk), .rst_n(s_rst_n),
    .rd0_valid(s_rd0_valid), .rd0_addr(s_rd0_addr), .rd0_ready(s_rd0_ready),
    .rd1_valid(s_rd1_valid), .rd1_addr(s_rd1_addr), .rd1_ready(s_rd1_ready),
    .rsp0_valid(s_rsp0_valid), .rsp0_data(s_rsp0_data),
    .rsp1_valid(s_rsp1_valid), .rsp1_data(s_rsp1_data),
    .wr_valid(s_wr_valid), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
    .clear_start(s_clear_start), .clear_value(s_clear_value), .clear_busy(s_clear_busy),
    .ram_waddr(s_ram_waddr), .ram_write_data(s_ram_write_data), .ram_write_en(s_ram_write_en),
    .ram_raddr(s_ram_raddr), .ram_read_data(s_ram_read_data)
  );

  always @(posedge clk) begin
    if (s_ram_write_en) mem_s[s_ram_waddr] <= s_ram_write_data;
    s_ram_read_data <= mem_s[s_ram_raddr];
  end

  task automatic reset_big();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rd0_valid = 1'b1; rd1_valid = 1'b1; wr_valid = 1'b1; clear_start = 1'b1;
    rd0_addr = 10'h005; rd1_addr = 10'h006;
    #1;
    total++; if (rd0_ready !== 1'b0) begin bad++; $display("FAIL reset_rd0_ready got %b want 0", rd0_ready); end
    total++; if (rd1_ready !== 1'b0) begin bad++; $display("FAIL reset_rd1_ready got %b want 0", rd1_ready); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
    total++; if (ram_write_en !== 1'b0) begin bad++; $display("FAIL reset_write_en got %b want 0", ram_write_en); end
    total++; if (ram_raddr !== 10'h000) begin bad++; $display("FAIL reset_raddr got %h want 000", ram_raddr); end
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp got %b%b want 00", rsp0_valid, rsp1_valid); end
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL reset_clear_busy got %b want 0", clear_busy); end
    total++; if (s_wr_ready !== 1'b0 || s_clear_busy !== 1'b0) begin bad++; $display("FAIL reset_small got ready=%b busy=%b want 0 0", s_wr_ready, s_clear_busy); end
    @(negedge clk);
    rd0_valid = 1'b0; rd1_valid = 1'b0; wr_valid = 1'b0; clear_start = 1'b0;
    rst_n = 1'b1; s_rst_n = 1'b1;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL post_reset_wr_ready got %b want 1", wr_ready); end
  endtask

  task automatic test_single_read();
    mem_b[10'h010] = 8'hA5;
    @(negedge clk); rd0_valid = 1'b1; rd0_addr = 10'h010;
    #1;
    total++; if (rd0_ready !== 1'b1) begin bad++; $display("FAIL single_ready got %b want 1", rd0_ready); end
    total++; if (ram_raddr !== 10'h010) begin bad++; $display("FAIL single_raddr got %h want 010", ram_raddr); end
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b1 || rsp0_data !== 8'hA5) begin bad++; $display("FAIL single_rsp got v=%b d=%h want 1 a5", rsp0_valid, rsp0_data); end
    total++; if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL single_rsp1 got %b want 0", rsp1_valid); end
    rd0_valid = 1'b0;
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_pulse got %b want 0", rsp0_valid); end
    #1;
    total++; if (ram_raddr !== 10'h010) begin bad++; $display("FAIL single_raddr_hold got %h want 010", ram_raddr); end
  endtask

  task automatic test_alternate();
    logic e0, e1;
    reset_big();
    mem_b[10'h020] = 8'h11; mem_b[10'h030] = 8'h22;
    rd0_addr = 10'h020; rd1_addr = 10'h030;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        e0 = (i - 1 < 4) && ((i - 1) % 2 == 0);
        e1 = (i - 1 < 4) && ((i - 1) % 2 == 1);
        total++; if (rsp0_valid !== e0) begin bad++; $display("FAIL alt_rsp0_%0d got %b want %b", i, rsp0_valid, e0); end
        total++; if (rsp1_valid !== e1) begin bad++; $display("FAIL alt_rsp1_%0d got %b want %b", i, rsp1_valid, e1); end
        if (e0) begin total++; if (rsp0_data !== 8'h11) begin bad++; $display("FAIL alt_d0_%0d got %h want 11", i, rsp0_data); end end
        if (e1) begin total++; if (rsp1_data !== 8'h22) begin bad++; $display("FAIL alt_d1_%0d got %h want 22", i, rsp1_data); end end
      end
      rd0_valid = (i < 4); rd1_valid = (i < 4);
      #1;
      if (i < 4) begin
        total++; if (rd0_ready !== (i % 2 == 0) || rd1_ready !== (i % 2 == 1))
          begin bad++; $display("FAIL alt_grant_%0d got %b%b want %b%b", i, rd0_ready, rd1_ready, (i % 2 == 0), (i % 2 == 1)); end
      end
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 10'h200; wr_data = 8'h3C;
    rd1_valid = 1'b1; rd1_addr = 10'h200;
    #1;
    total++; if (rd1_ready !== 1'b0) begin bad++; $display("FAIL coll_stall got %b want 0", rd1_ready); end
    total++; if (wr_ready !== 1'b1 || ram_write_en !== 1'b1 || ram_waddr !== 10'h200 || ram_write_data !== 8'h3C)
      begin bad++; $display("FAIL coll_write got rdy=%b en=%b a=%h d=%h want 1 1 200 3c", wr_ready, ram_write_en, ram_waddr, ram_write_data); end
    @(negedge clk);
    total++; if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL coll_no_rsp got %b want 0", rsp1_valid); end
    wr_valid = 1'b0;
    #1;
    total++; if (rd1_ready !== 1'b1) begin bad++; $display("FAIL coll_retry got %b want 1", rd1_ready); end
    @(negedge clk);
    total++; if (rsp1_valid !== 1'b1 || rsp1_data !== 8'h3C) begin bad++; $display("FAIL coll_rsp got v=%b d=%h want 1 3c", rsp1_valid, rsp1_data); end
    rd1_valid = 1'b0;
  endtask

  task automatic test_reset_drops_rsp();
    @(negedge clk); rd0_valid = 1'b1; rd0_addr = 10'h010;
    @(negedge clk); rd0_valid = 1'b0; rst_n = 1'b0;
    #1;
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL rst_drop_rsp got %b want 0", rsp0_valid); end
    total++; if (ram_raddr !== 10'h000) begin bad++; $display("FAIL rst_drop_raddr got %h want 000", ram_raddr); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 16; i++) mem_s[i] = 8'(i);
    @(negedge clk); s_clear_start = 1'b1; s_clear_value = 8'hFF;
    #1;
    total++; if (s_clear_busy !== 1'b0) begin bad++; $display("FAIL clr_busy_pre got %b want 0", s_clear_busy); end
    @(negedge clk); s_clear_start = 1'b0; s_clear_value = 8'h00;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      total++; if (s_clear_busy !== 1'b1 || s_wr_ready !== 1'b0 || s_ram_write_en !== 1'b1 ||
                   s_ram_waddr !== 4'(k) || s_ram_write_data !== 8'hFF)
        begin bad++; $display("FAIL clr_cycle_%0d got busy=%b rdy=%b en=%b a=%h d=%h want 1 0 1 %h ff", k, s_clear_busy, s_wr_ready, s_ram_write_en, s_ram_waddr, s_ram_write_data, 4'(k)); end
    end
    @(negedge clk);
    total++; if (s_clear_busy !== 1'b0 || s_wr_ready !== 1'b1) begin bad++; $display("FAIL clr_done got busy=%b rdy=%b want 0 1", s_clear_busy, s_wr_ready); end
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        @(negedge clk);
        total++; if (s_rsp0_valid !== 1'b1 || s_rsp0_data !== 8'hFF) begin bad++; $display("FAIL clr_read_%0d got v=%b d=%h want 1 ff", i - 1, s_rsp0_valid, s_rsp0_data); end
      end
      if (i < 16) begin
        s_rd0_valid = 1'b1; s_rd0_addr = 4'(i);
        #1;
        total++; if (s_rd0_ready !== 1'b1) begin bad++; $display("FAIL clr_read_rdy_%0d got %b want 1", i, s_rd0_ready); end
      end else s_rd0_valid = 1'b0;
    end
  endtask

  task automatic test_clear_overlap();
    int busy_cnt;
    busy_cnt = 0;
    mem_s[3] = 8'h00;
    @(negedge clk);
    s_wr_valid = 1'b1; s_wr_addr = 4'h3; s_wr_data = 8'h5A;
    s_clear_start = 1'b1; s_clear_value = 8'h77;
    #1;
    total++; if (s_wr_ready !== 1'b1 || s_ram_write_en !== 1'b1 || s_ram_waddr !== 4'h3 || s_ram_write_data !== 8'h5A)
      begin bad++; $display("FAIL ovl_host got rdy=%b en=%b a=%h d=%h want 1 1 3 5a", s_wr_ready, s_ram_write_en, s_ram_waddr, s_ram_write_data); end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total++; if (mem_s[3] !== 8'h5A) begin bad++; $display("FAIL ovl_host_mem got %h want 5a", mem_s[3]); end
        s_wr_valid = 1'b0; s_clear_start = 1'b0;
      end
      if (k == 4) begin s_clear_start = 1'b1; s_clear_value = 8'h11; end
      if (k == 5) begin
        s_clear_start = 1'b0;
        total++; if (s_ram_waddr !== 4'h5 || s_ram_write_data !== 8'h77) begin bad++; $display("FAIL ovl_no_restart got a=%h d=%h want 5 77", s_ram_waddr, s_ram_write_data); end
      end
      if (s_clear_busy) busy_cnt++;
    end
    total++; if (busy_cnt !== 16) begin bad++; $display("FAIL ovl_busy_len got %0d want 16", busy_cnt); end
  endtask

  task automatic test_clear_abort();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) mem_s[i] = 8'h40 + 8'(i);
    @(negedge clk); s_clear_start = 1'b1; s_clear_value = 8'hC3;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      s_clear_start = 1'b0;
    end
    s_rst_n = 1'b0;
    #1;
    total++; if (s_clear_busy !== 1'b0 || s_ram_write_en !== 1'b0) begin bad++; $display("FAIL abort_drop got busy=%b en=%b want 0 0", s_clear_busy, s_ram_write_en); end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      exp = (i < 5) ? 8'hC3 : 8'h40 + 8'(i);
      total++; if (mem_s[i] !== exp) begin bad++; $display("FAIL abort_mem_%0d got %h want %h", i, mem_s[i], exp); end
    end
    s_rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; s_rst_n = 1'b0;
    rd0_valid = 1'b0; rd1_valid = 1'b0; rd0_addr = '0; rd1_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clear_start = 1'b0; clear_value = '0;
    s_rd0_valid = 1'b0; s_rd1_valid = 1'b0; s_rd0_addr = '0; s_rd1_addr = '0;
    s_wr_valid = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_clear_start = 1'b0; s_clear_value = '0;
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem_s[i] = 8'h00;
    test_reset();
    test_single_read();
    test_alternate();
    test_collision();
    test_reset_drops_rsp();
    test_clear();
    test_clear_overlap();
    test_clear_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vram_port_scheduler.md
# vram_port_scheduler

Single-clock scheduler that owns both ports of the PPU's simple dual-port video RAM. It round-robins two read requesters (tile fetcher, sprite fetcher) onto the read port with fixed 1-cycle response latency. It multiplexes host writes and a built-in clear/fill engine onto the write port. It stalls any read that would hit the address being written in the same cycle.

## Interface

- ADDR_W, 14, address width; RAM depth is 2^ADDR_W
- DATA_W, 8, word width
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd0_valid / rd1_valid  in  1  read request from requester 0 / 1
- rd0_addr / rd1_addr  in  ADDR_W  read address
- rd0_ready / rd1_ready  out  1  request accepted this cycle (valid & ready)
- rsp0_valid / rsp1_valid  out  1  read data valid, one cycle pulse
- rsp0_data / rsp1_data  out  DATA_W  read data, meaningful only when rspN_valid
- wr_valid  in  1  host write request
- wr_addr  in  ADDR_W  host write address
- wr_data  in  DATA_W  host write data
- wr_ready  out  1  host write accepted this cycle
- clear_start  in  1  pulse: fill entire RAM with clear_value
- clear_value  in  DATA_W  fill word, sampled on the accepted clear_start
- clear_busy  out  1  fill in progress
- ram_waddr  out  ADDR_W  to RAM write address
- ram_write_data  out  DATA_W  to RAM write data
- ram_write_en  out  1  to RAM write enable
- ram_raddr  out  ADDR_W  to RAM read address
- ram_read_data  in  DATA_W  from RAM; registered, valid the cycle after raddr is sampled

## Operation

- Write FSM states: IDLE, CLEAR. Reset -> IDLE.
- IDLE: wr_ready = 1. ram_write_en = wr_valid, and ram_waddr/ram_write_data = wr_addr/wr_data. clear_start -> CLEAR next cycle. It latches clear_value and sets clear counter = 0. A host write in the same cycle as clear_start is still performed.
- CLEAR: wr_ready = 0. ram_write_en = 1, ram_waddr = counter, ram_write_data = latched value. The counter increments each cycle. After writing address 2^ADDR_W-1, the counter wraps to 0 and the FSM returns to IDLE. clear_start is ignored while in CLEAR.
- clear_busy = (state == CLEAR).
- Active write address this cycle = ram_waddr when ram_write_en = 1, otherwise none.
- Read arbitration:
  - A requester is eligible when it is valid and its address differs from the active write address.
  - If both are eligible, grant the one not granted last. last_grant resets to 1, so requester 0 wins the first tie.
  - If exactly one is eligible, grant it.
  - At most one grant per cycle. rdN_ready = grant to N.
  - last_grant updates only on an actual grant.
- ram_raddr = address of the granted requester. If there is no grant, it holds the previous ram_raddr (registered copy).
- Response: a registered flag records grant N. In the following cycle rspN_valid = 1 and rspN_data = ram_read_data. There is no response backpressure.
- A blocked (colliding) requester must hold valid and address. It is retried every cycle.

## Timing

- While rst_n = 0: all ready outputs 0, rsp*_valid 0, clear_busy 0, ram_write_en 0, ram_raddr 0, last_grant 1. Ready outputs are gated combinationally by rst_n.
- Read latency: accepted at edge T -> rspN_valid high during cycle T+1. Throughput is 1 read per cycle total.
- Write latency: the host write reaches RAM on the same edge it is accepted.
- A clear occupies exactly 2^ADDR_W cycles after the start edge.
- rst_n asserted mid-clear: the clear aborts immediately and memory is left partially filled. Pending responses are dropped; rsp*_valid = 0.

## Test plan

- Reset, then rd0 valid at 0x0010 with RAM[0x0010]=0xA5 -> rd0_ready same cycle, rsp0_valid=1 and rsp0_data=0xA5 next cycle only.
- rd0 and rd1 both held valid for 4 cycles -> grants alternate 0,1,0,1, and each rsp pulses exactly once per grant.
- Host write 0x0200<-0x3C while rd1 requests 0x0200 -> rd1_ready=0 that cycle. Next cycle rd1 is granted, and rsp1_data=0x3C the cycle after.
- ADDR_W=4, clear_start with clear_value=0xFF -> clear_busy high 16 cycles, ram_waddr 0..15, wr_ready=0 throughout, all 16 words read back as 0xFF.
- clear_start with wr_valid same cycle -> host write performed. Second clear_start during CLEAR -> no restart, busy still ends after 16 cycles.
- rst_n low at clear cycle 5 -> clear_busy and ram_write_en drop immediately. Addresses 5..15 keep their old contents.
